// File: rtl/uk101_loader_pkg.sv
`default_nettype none
// uk101_loader_pkg - loader state encoding and ASCII constants shared by ascii_loader.
// Rev 1.0 - initial release.
package uk101_loader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        OFFER = 2'd2,
        GAP   = 2'd3
    } loader_state_t;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

endpackage
`default_nettype wire

// File: rtl/loader_fifo.sv
`default_nettype none
// loader_fifo - show-ahead byte FIFO; flush with a simultaneous push leaves only the new byte.
// Rev 1.0 - initial release.
module loader_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   n_reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  logic [7:0]             din,
    output logic [7:0]             dout,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (AW + 1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty && !flush;
    // A pop in the same cycle frees the slot, so a push to a full FIFO still lands.
    assign do_push = push && (flush || !full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= do_push ? AW'(1) : '0;
            count  <= do_push ? (AW + 1)'(1) : '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + (AW + 1)'(1);
            end else if (do_pop && !do_push) begin
                count <= count - (AW + 1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[flush ? '0 : wr_ptr] <= din;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ascii_loader.sv
`default_nettype none
// ascii_loader - paces HPS-downloaded ASCII files into the UK101 serial receive path.
// Rev 1.0 - initial release. Option macro: ASCII_LOADER_LF_XLATE_EN (CR LF -> CR, bare LF -> CR).
module ascii_loader
    import uk101_loader_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int CHAR_GAP   = 48000,
    parameter int LINE_GAP   = 960000
) (
    input  logic        clk,
    input  logic        n_reset,
    input  logic        ioctl_download,
    input  logic        ioctl_wr,
    input  logic [15:0] ioctl_addr,
    input  logic [7:0]  ioctl_data,
    output logic        ioctl_wait,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    input  logic        rx_ready,
    output logic        busy,
    output logic        overflow
);

    localparam int              CW         = $clog2(FIFO_DEPTH) + 1;
    localparam int              GW         = $clog2(LINE_GAP + 1);
    localparam logic [GW-1:0]   LINE_LOAD  = GW'(LINE_GAP);
    localparam logic [GW-1:0]   CHAR_LOAD  = GW'(CHAR_GAP);
    // Two free slots left when wait rises: one for the write already in flight.
    localparam logic [CW-1:0]   WAIT_LEVEL = CW'(FIFO_DEPTH - 2);

    loader_state_t st;
    logic [GW-1:0] gap;
    logic          wr_en;
    logic          flush;
    logic          fifo_pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [7:0]    fifo_dout;
    logic [CW-1:0] fifo_count;
    logic [7:0]    out_byte;
    logic          xlate_drop;

    assign wr_en    = ioctl_download && ioctl_wr;
    assign flush    = wr_en && (ioctl_addr == 16'd0);
    assign fifo_pop = (st == LOAD) && !fifo_empty && !flush;
    assign busy     = ioctl_download || (st != IDLE) || !fifo_empty;

`ifdef ASCII_LOADER_LF_XLATE_EN
    logic last_cr;

    assign xlate_drop = (fifo_dout == ASCII_LF) && last_cr;
    assign out_byte   = (fifo_dout == ASCII_LF) ? ASCII_CR : fifo_dout;
`else
    assign xlate_drop = 1'b0;
    assign out_byte   = fifo_dout;
`endif

    loader_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .n_reset (n_reset),
        .push    (wr_en),
        .pop     (fifo_pop),
        .flush   (flush),
        .din     (ioctl_data),
        .dout    (fifo_dout),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            st         <= IDLE;
            gap        <= '0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            ioctl_wait <= 1'b0;
            overflow   <= 1'b0;
`ifdef ASCII_LOADER_LF_XLATE_EN
            last_cr    <= 1'b0;
`endif
        end else begin
            ioctl_wait <= (fifo_count >= WAIT_LEVEL);

            if (flush) begin
                overflow <= 1'b0;
            end else if (wr_en && fifo_full && !fifo_pop) begin
                overflow <= 1'b1;
            end

            // A new file abandons whatever was pending; its first byte is loaded next.
            if (flush) begin
                st       <= LOAD;
                gap      <= '0;
                rx_data  <= '0;
                rx_valid <= 1'b0;
`ifdef ASCII_LOADER_LF_XLATE_EN
                last_cr  <= 1'b0;
`endif
            end else begin
                case (st)
                    IDLE: begin
                        if (!fifo_empty || wr_en) begin
                            st <= LOAD;
                        end
                    end
                    LOAD: begin
                        if (fifo_empty) begin
                            st <= IDLE;
                        end else begin
`ifdef ASCII_LOADER_LF_XLATE_EN
                            last_cr <= (fifo_dout == ASCII_CR);
`endif
                            if (xlate_drop) begin
                                st <= ((fifo_count > CW'(1)) || wr_en) ? LOAD : IDLE;
                            end else begin
                                rx_data  <= out_byte;
                                rx_valid <= 1'b1;
                                st       <= OFFER;
                            end
                        end
                    end
                    OFFER: begin
                        if (rx_ready) begin
                            rx_valid <= 1'b0;
                            gap      <= (rx_data == ASCII_CR) ? LINE_LOAD : CHAR_LOAD;
                            st       <= GAP;
                        end
                    end
                    GAP: begin
                        if (gap == '0) begin
                            st <= fifo_empty ? IDLE : LOAD;
                        end else begin
                            gap <= gap - GW'(1);
                        end
                    end
                    default: st <= IDLE;
                endcase
            end
        end
    end

endmodule
`default_nettype wire
